// File: rtl/sprite_cmd_unit.sv
// sprite_cmd_unit
//   Execution-side responder for the sprite command stream. Holds a
//   NUM_SPRITES-entry attribute store (single-port RAM, synchronous read)
//   and performs read-modify-write updates for write commands. It returns
//   formatted entry data for read commands. A renderer scan port shares the
//   RAM and always wins arbitration.
//
//   Entry word: {active[31], img[30:24], y[23:12], x[11:0]}
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     sprite_we/re        write / read command request (write wins if both)
//     sprite_action       action code (writes 0..7 legal, 8..15 illegal;
//                         reads use bit 0: 0 = RD full word, 1 = CORD)
//     sprite_addr         sprite index
//     sprite_use_imm      operand source: 1 = sprite_imm, 0 = sprite_reg_data
//     sprite_imm          14-bit immediate operand
//     sprite_reg_data     32-bit register operand
//     dst_reg             writeback register for reads
//     stall               unit busy (state != IDLE)
//     rd_valid            one-cycle read response strobe
//     rd_data, rd_dst_reg read response and its writeback register
//     cmd_err             one-cycle pulse on an illegal write action
//     scan_re, scan_addr  renderer read request (data one cycle later)
//     scan_data           renderer read data, 0 when no granted scan read
//
//   Build option: define SPRITE_INIT_CLEAR_EN to zero the whole store after
//   reset (stall held high during the clear).

module sprite_cmd_unit #(
    parameter int unsigned NUM_SPRITES = 256,
    parameter int unsigned COORD_W     = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sprite_we,
    input  logic        sprite_re,
    input  logic [3:0]  sprite_action,
    input  logic [7:0]  sprite_addr,
    input  logic        sprite_use_imm,
    input  logic [13:0] sprite_imm,
    input  logic [31:0] sprite_reg_data,
    input  logic [4:0]  dst_reg,
    output logic        stall,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [4:0]  rd_dst_reg,
    output logic        cmd_err,
    input  logic        scan_re,
    input  logic [7:0]  scan_addr,
    output logic [31:0] scan_data
);

    localparam int unsigned Y_LSB   = COORD_W;
    localparam int unsigned IMG_LSB = 2 * COORD_W;
    localparam int unsigned ACT_BIT = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WB,
        ST_CLR
    } state_t;

    state_t state_q, state_d;

    // Latched command
    logic [3:0]         action_q;
    logic [7:0]         addr_q;
    logic [IMG_LSB-1:0] op_q;
    logic [COORD_W-1:0] delta_q;
    logic [4:0]         dst_q;
    logic               is_wr_q;

    logic [31:0]        word_q;
    logic               scan_hit_q;

    // Store and its single access port
    logic [31:0]        mem_q [NUM_SPRITES];
    logic [31:0]        ram_dout_q;
    logic               ram_re;
    logic               ram_we;
    logic [7:0]         ram_addr;
    logic [31:0]        ram_wdata;

`ifdef SPRITE_INIT_CLEAR_EN
    logic [7:0]         clr_q;
`endif

    logic               req;
    logic               illegal;
    logic [31:0]        op_d;
    logic [COORD_W-1:0] delta_d;
    logic [31:0]        word_new;
    logic [31:0]        cord_word;
    logic               unused_op;

    assign req     = sprite_we | sprite_re;
    assign illegal = action_q[3];
    assign op_d    = sprite_use_imm ? {18'b0, sprite_imm} : sprite_reg_data;
    // Only the low COORD_W bits of the delta reach the wrapping sum, and
    // those bits are identical with or without sign extension of the imm.
    assign delta_d = sprite_use_imm ? sprite_imm[COORD_W-1:0]
                                    : sprite_reg_data[COORD_W-1:0];
    assign unused_op = ^op_d[31:IMG_LSB];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef SPRITE_INIT_CLEAR_EN
            state_q <= ST_CLR;
`else
            state_q <= ST_IDLE;
`endif
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) state_d = scan_re ? ST_RD : ST_CAP;
            end
            ST_RD: begin
                if (!scan_re) state_d = ST_CAP;
            end
            ST_CAP: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                // Reads and illegal writes never touch the RAM here, so only
                // a legal write has to wait out scan contention.
                if (!is_wr_q || illegal || !scan_re) state_d = ST_IDLE;
            end
`ifdef SPRITE_INIT_CLEAR_EN
            ST_CLR: begin
                if (!scan_re && clr_q == 8'(NUM_SPRITES - 1)) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs and RAM port control
    // ------------------------------------------------------------------
    always_comb begin
        stall      = (state_q != ST_IDLE);
        rd_valid   = 1'b0;
        rd_data    = '0;
        rd_dst_reg = '0;
        cmd_err    = 1'b0;
        ram_re     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = scan_addr;
        ram_wdata  = '0;

        if (scan_re) begin
            ram_re = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        ram_re   = 1'b1;
                        ram_addr = sprite_addr;
                    end
                end
                ST_RD: begin
                    ram_re   = 1'b1;
                    ram_addr = addr_q;
                end
                ST_WB: begin
                    if (is_wr_q && !illegal) begin
                        ram_we    = 1'b1;
                        ram_addr  = addr_q;
                        ram_wdata = word_new;
                    end
                end
`ifdef SPRITE_INIT_CLEAR_EN
                ST_CLR: begin
                    ram_we   = 1'b1;
                    ram_addr = clr_q;
                end
`endif
                default: ;
            endcase
        end

        if (state_q == ST_WB) begin
            if (is_wr_q) begin
                cmd_err = illegal;
            end else begin
                rd_valid   = 1'b1;
                rd_data    = action_q[0] ? cord_word : word_q;
                rd_dst_reg = dst_q;
            end
        end

        scan_data = scan_hit_q ? ram_dout_q : '0;
    end

    // ------------------------------------------------------------------
    // Modified word for write actions and CORD read formatting
    // ------------------------------------------------------------------
    always_comb begin
        word_new = word_q;
        case (action_q)
            4'd0: word_new[Y_LSB-1:0]         = op_q[COORD_W-1:0];
            4'd1: word_new[IMG_LSB-1:Y_LSB]   = op_q[COORD_W-1:0];
            4'd2: word_new[ACT_BIT-1:IMG_LSB] = op_q[ACT_BIT-1-IMG_LSB:0];
            4'd3: word_new[ACT_BIT]           = 1'b1;
            4'd4: word_new[ACT_BIT]           = 1'b0;
            4'd5: word_new[Y_LSB-1:0]         = word_q[Y_LSB-1:0] + delta_q;
            4'd6: word_new[IMG_LSB-1:Y_LSB]   = word_q[IMG_LSB-1:Y_LSB] + delta_q;
            4'd7: begin
                word_new[Y_LSB-1:0]       = op_q[COORD_W-1:0];
                word_new[IMG_LSB-1:Y_LSB] = op_q[IMG_LSB-1:COORD_W];
            end
            default: ;
        endcase
    end

    always_comb begin
        cord_word                     = '0;
        cord_word[COORD_W-1:0]        = word_q[Y_LSB-1:0];
        cord_word[16+COORD_W-1:16]    = word_q[IMG_LSB-1:Y_LSB];
    end

    // ------------------------------------------------------------------
    // Command latch, word capture, scan tracking, clear counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            action_q   <= '0;
            addr_q     <= '0;
            op_q       <= '0;
            delta_q    <= '0;
            dst_q      <= '0;
            is_wr_q    <= 1'b0;
            word_q     <= '0;
            scan_hit_q <= 1'b0;
        end else begin
            scan_hit_q <= scan_re;
            if (state_q == ST_IDLE && req) begin
                action_q <= sprite_action;
                addr_q   <= sprite_addr;
                op_q     <= op_d[IMG_LSB-1:0];
                delta_q  <= delta_d;
                dst_q    <= dst_reg;
                is_wr_q  <= sprite_we;
            end
            if (state_q == ST_CAP) begin
                word_q <= ram_dout_q;
            end
        end
    end

`ifdef SPRITE_INIT_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_q <= '0;
        end else if (state_q == ST_CLR && !scan_re) begin
            clr_q <= clr_q + 8'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Single-port store, synchronous read
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_addr] <= ram_wdata;
        end
        if (ram_re) begin
            ram_dout_q <= mem_q[ram_addr];
        end
    end

endmodule

// File: tb/tb_sprite_cmd_unit.sv
// tb_sprite_cmd_unit
//   Directed stimulus with hand-computed expected values. Read responses and
//   scan data are pushed into queues when issued; a negedge monitor pops and
//   compares whenever the DUT presents them.

module tb_sprite_cmd_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sprite_we = 1'b0;
    logic        sprite_re = 1'b0;
    logic [3:0]  sprite_action = '0;
    logic [7:0]  sprite_addr = '0;
    logic        sprite_use_imm = 1'b0;
    logic [13:0] sprite_imm = '0;
    logic [31:0] sprite_reg_data = '0;
    logic [4:0]  dst_reg = '0;
    logic        stall;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [4:0]  rd_dst_reg;
    logic        cmd_err;
    logic        scan_re = 1'b0;
    logic [7:0]  scan_addr = '0;
    logic [31:0] scan_data;

`ifdef SPRITE_INIT_CLEAR_EN
    localparam logic [31:0] RST_STALL = 32'd1;
    localparam int          CLR_CYCLES = 256;
`else
    localparam logic [31:0] RST_STALL = 32'd0;
    localparam int          CLR_CYCLES = 0;
`endif

    sprite_cmd_unit #(
        .NUM_SPRITES(256),
        .COORD_W(12)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sprite_we(sprite_we),
        .sprite_re(sprite_re),
        .sprite_action(sprite_action),
        .sprite_addr(sprite_addr),
        .sprite_use_imm(sprite_use_imm),
        .sprite_imm(sprite_imm),
        .sprite_reg_data(sprite_reg_data),
        .dst_reg(dst_reg),
        .stall(stall),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_dst_reg(rd_dst_reg),
        .cmd_err(cmd_err),
        .scan_re(scan_re),
        .scan_addr(scan_addr),
        .scan_data(scan_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        logic [4:0]  dst;
        int          cyc;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [31:0] scan_q[$];
    rd_exp_t     e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          err_cycles = 0;
    logic        scan_prev = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endfunction

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        scan_prev <= scan_re;
    end

    // Monitor
    always @(negedge clk) begin
        if (cmd_err) err_cycles++;
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_valid with data %08h expected no response", rd_data);
            end else begin
                e = rd_q.pop_front();
                chk("rd_data", rd_data & e.mask, e.data & e.mask);
                chk("rd_dst_reg", {27'b0, rd_dst_reg}, {27'b0, e.dst});
                chk("rd_latency", cyc, e.cyc);
            end
        end
        if (scan_prev) begin
            if (scan_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scan_unexpected: got scan data %08h expected none", scan_data);
            end else begin
                chk("scan_data", scan_data, scan_q.pop_front());
            end
        end else begin
            chk("scan_idle_zero", scan_data, 32'h0);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one command at the current cycle (k = 0) and runs until stall
    // drops. scan_re is driven for cycles k in [scan_from, scan_from+scan_len).
    task automatic run_cmd(input logic we, input logic re, input logic [3:0] act,
                           input logic [7:0] addr, input logic use_imm,
                           input logic [13:0] imm, input logic [31:0] rdata,
                           input logic [4:0] dst, input int scan_from,
                           input int scan_len, input logic [7:0] s_addr,
                           input logic [31:0] s_exp, output int n);
        int k;
        sprite_we       = we;
        sprite_re       = re;
        sprite_action   = act;
        sprite_addr     = addr;
        sprite_use_imm  = use_imm;
        sprite_imm      = imm;
        sprite_reg_data = rdata;
        dst_reg         = dst;
        k = 0;
        scan_addr = s_addr;
        scan_re   = (k >= scan_from && k < scan_from + scan_len);
        if (scan_re) scan_q.push_back(s_exp);
        cycle();
        sprite_we = 1'b0;
        sprite_re = 1'b0;
        k = 1;
        n = 0;
        while (stall && k < 200) begin
            n++;
            scan_re = (k >= scan_from && k < scan_from + scan_len);
            if (scan_re) scan_q.push_back(s_exp);
            cycle();
            k++;
        end
        scan_re = 1'b0;
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout: got stall high for %0d cycles expected it to drop", k);
        end
    endtask

    task automatic wr(input logic [3:0] act, input logic [7:0] addr, input logic use_imm,
                      input logic [13:0] imm, input logic [31:0] rdata);
        int n;
        run_cmd(1'b1, 1'b0, act, addr, use_imm, imm, rdata, 5'd0, 0, 0, 8'd0, 32'd0, n);
        chk("stall_cycles_wr", n, 32'd2);
    endtask

    task automatic rd(input logic cord, input logic [7:0] addr, input logic [4:0] dst,
                      input logic [31:0] exp, input logic [31:0] mask);
        int n;
        rd_q.push_back('{exp, mask, dst, cyc + 2});
        run_cmd(1'b0, 1'b1, {3'b000, cord}, addr, 1'b0, 14'd0, 32'd0, dst, 0, 0, 8'd0, 32'd0, n);
        chk("stall_cycles_rd", n, 32'd2);
    endtask

    task automatic wait_idle(input string name, input int exp_n);
        int n;
        n = 0;
        while (stall && n < 1000) begin
            cycle();
            n++;
        end
        chk(name, n, exp_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, RST_STALL);
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_rd_dst_reg", {27'b0, rd_dst_reg}, 32'd0);
        chk("rst_cmd_err", {31'b0, cmd_err}, 32'd0);
        chk("rst_scan_data", scan_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_idle("init_clear_cycles", CLR_CYCLES);

        // Sprite 5: field writes and both read formats
        wr(4'd0, 8'd5, 1'b1, 14'h0123, 32'd0);
        rd(1'b0, 8'd5, 5'd7, 32'h0000_0123, 32'h0000_0FFF);
        wr(4'd1, 8'd5, 1'b1, 14'h0456, 32'd0);
        wr(4'd2, 8'd5, 1'b1, 14'h3FD5, 32'd0);
        wr(4'd3, 8'd5, 1'b1, 14'h0000, 32'd0);
        rd(1'b0, 8'd5, 5'd7, 32'hD545_6123, 32'hFFFF_FFFF);
        wr(4'd4, 8'd5, 1'b1, 14'h0000, 32'd0);
        rd(1'b0, 8'd5, 5'd1, 32'h5545_6123, 32'hFFFF_FFFF);
        rd(1'b1, 8'd5, 5'd2, 32'h0456_0123, 32'hFFFF_FFFF);

        // Sprite 6: register operands, SET_XY, CORD
        wr(4'd7, 8'd6, 1'b0, 14'h0000, 32'h00AB_C123);
        rd(1'b1, 8'd6, 5'd3, 32'h0ABC_0123, 32'hFFFF_FFFF);
        wr(4'd0, 8'd6, 1'b0, 14'h0000, 32'hFFFF_F7E5);
        wr(4'd2, 8'd6, 1'b1, 14'h0012, 32'd0);
        wr(4'd4, 8'd6, 1'b1, 14'h0000, 32'd0);
        rd(1'b0, 8'd6, 5'd10, 32'h12AB_C7E5, 32'hFFFF_FFFF);

        // Sprite 7: wrapping moves in both directions
        wr(4'd7, 8'd7, 1'b0, 14'h0000, 32'h0000_0000);
        wr(4'd0, 8'd7, 1'b1, 14'h0FFE, 32'd0);
        wr(4'd5, 8'd7, 1'b1, 14'h0004, 32'd0);
        rd(1'b1, 8'd7, 5'd4, 32'h0000_0002, 32'hFFFF_FFFF);
        wr(4'd5, 8'd7, 1'b1, 14'h3FFD, 32'd0);
        rd(1'b1, 8'd7, 5'd5, 32'h0000_0FFF, 32'hFFFF_FFFF);
        wr(4'd6, 8'd7, 1'b0, 14'h0000, 32'hFFFF_FFFF);
        rd(1'b1, 8'd7, 5'd6, 32'h0FFF_0FFF, 32'hFFFF_FFFF);
        wr(4'd6, 8'd7, 1'b1, 14'h0002, 32'd0);
        rd(1'b1, 8'd7, 5'd8, 32'h0001_0FFF, 32'hFFFF_FFFF);

        // Scan held for 3 WB cycles of a write: old word seen, write 3 late
        run_cmd(1'b1, 1'b0, 4'd0, 8'd6, 1'b1, 14'h0001, 32'd0, 5'd0,
                2, 3, 8'd6, 32'h12AB_C7E5, n);
        chk("stall_cycles_wr_scan", n, 32'd5);
        rd(1'b0, 8'd6, 5'd11, 32'h12AB_C001, 32'hFFFF_FFFF);

        // Scan in the accept cycle and RD cycle of a read: two extra cycles
        rd_q.push_back('{32'h5545_6123, 32'hFFFF_FFFF, 5'd12, cyc + 4});
        run_cmd(1'b0, 1'b1, 4'd0, 8'd5, 1'b0, 14'd0, 32'd0, 5'd12,
                0, 2, 8'd6, 32'h12AB_C001, n);
        chk("stall_cycles_rd_scan", n, 32'd4);

        // Sprite 9: illegal actions and simultaneous we/re
        wr(4'd7, 8'd9, 1'b0, 14'h0000, 32'h0032_1654);
        wr(4'd2, 8'd9, 1'b1, 14'h007F, 32'd0);
        wr(4'd3, 8'd9, 1'b1, 14'h0000, 32'd0);
        wr(4'hA, 8'd9, 1'b1, 14'h0155, 32'd0);
        chk("cmd_err_cycles_a", err_cycles, 32'd1);
        rd(1'b0, 8'd9, 5'd13, 32'hFF32_1654, 32'hFFFF_FFFF);
        run_cmd(1'b1, 1'b0, 4'hF, 8'd9, 1'b1, 14'h0000, 32'd0, 5'd0,
                2, 1, 8'd9, 32'hFF32_1654, n);
        chk("stall_cycles_illegal_scan", n, 32'd2);
        chk("cmd_err_cycles_f", err_cycles, 32'd2);
        run_cmd(1'b1, 1'b1, 4'd0, 8'd9, 1'b1, 14'h00AA, 32'd0, 5'd4,
                0, 0, 8'd0, 32'd0, n);
        chk("stall_cycles_we_re", n, 32'd2);
        rd(1'b0, 8'd9, 5'd14, 32'hFF32_10AA, 32'hFFFF_FFFF);

        // Reset during the CAP cycle of a write
        sprite_we      = 1'b1;
        sprite_action  = 4'd0;
        sprite_addr    = 8'd9;
        sprite_use_imm = 1'b1;
        sprite_imm     = 14'h0555;
        cycle();
        sprite_we = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", {31'b0, stall}, RST_STALL);
        chk("midrst_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("midrst_rd_data", rd_data, 32'd0);
        chk("midrst_rd_dst_reg", {27'b0, rd_dst_reg}, 32'd0);
        chk("midrst_cmd_err", {31'b0, cmd_err}, 32'd0);
        chk("midrst_scan_data", scan_data, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_idle("midrst_clear_cycles", CLR_CYCLES);
`ifdef SPRITE_INIT_CLEAR_EN
        rd(1'b0, 8'd255, 5'd16, 32'h0000_0000, 32'hFFFF_FFFF);
        rd(1'b0, 8'd9, 5'd15, 32'h0000_0000, 32'hFFFF_FFFF);
`else
        rd(1'b0, 8'd9, 5'd15, 32'hFF32_10AA, 32'hFFFF_FFFF);
`endif

        repeat (3) cycle();
        chk("rd_queue_drained", rd_q.size(), 32'd0);
        chk("scan_queue_drained", scan_q.size(), 32'd0);
        chk("cmd_err_total", err_cycles, 32'd2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_cmd_unit.md
# sprite_cmd_unit

Execution-side responder for the sprite command stream produced by instruction decode. It accepts sprite write commands (ACT/LD/MAP/TM, `sprite_we`) and sprite read commands (RD/CORD, `sprite_re`). It holds a 256-entry sprite attribute store and performs read-modify-write updates. It returns read data and the destination register for writeback, stalling the pipeline while a command is in flight. A renderer scan port shares the store and always has priority.

## Interface
Parameters:
- `NUM_SPRITES`, 256: store depth; must match the 8-bit `sprite_addr`.
- `COORD_W`, 12: width of each of the X and Y fields.

Ports:
- `clk` in 1: the single clock; everything below is synchronous to it.
- `rst_n` in 1: asynchronous, active-low reset.
- `sprite_we` in 1: write-command request.
- `sprite_re` in 1: read-command request.
- `sprite_action` in 4: action code.
- `sprite_addr` in 8: sprite index.
- `sprite_use_imm` in 1: selects the operand source (1 = immediate, 0 = register data).
- `sprite_imm` in 14: immediate operand.
- `sprite_reg_data` in 32: register operand.
- `dst_reg` in 5: writeback register for reads.
- `stall` out 1: unit busy; upstream must hold the next command.
- `rd_valid` out 1: read response strobe.
- `rd_data` out 32: read response data.
- `rd_dst_reg` out 5: writeback register that goes with `rd_data`.
- `cmd_err` out 1: one-cycle pulse on an illegal write action.
- `scan_re` in 1: renderer read request.
- `scan_addr` in 8: renderer read index.
- `scan_data` out 32: renderer read data.

## Operation
Entry word format: {active[31], img[30:24], y[23:12], x[11:0]}.

Operand:
- `op` = `sprite_use_imm` ? {18'b0, `sprite_imm`} : `sprite_reg_data`.
- `delta` = `sprite_use_imm` ? sign-extended `sprite_imm` : `sprite_reg_data`.

Write actions:
- 0 SET_X: x = op[11:0].
- 1 SET_Y: y = op[11:0].
- 2 SET_IMG: img = op[6:0].
- 3 ENABLE: active = 1.
- 4 DISABLE: active = 0.
- 5 MOVE_X: x = (x + delta)[11:0]. Result wraps modulo 4096; no saturation.
- 6 MOVE_Y: y = (y + delta)[11:0]. Wraps the same way.
- 7 SET_XY: x = op[11:0], y = op[23:12].
- 8–15 illegal: no RAM write; `cmd_err` pulses.

Read formats:
- `sprite_action[0]` = 0 (RD): the full entry word.
- `sprite_action[0]` = 1 (CORD): {4'h0, y, 4'h0, x}.

Requests:
- If `sprite_we` and `sprite_re` are both high, the write takes precedence and the read is dropped.

The store is single-port RAM with synchronous read. Port arbitration: the scan read wins over any command access in the same cycle.

FSM states:
- IDLE:
  - On a request, latch action, addr, op, delta, dst_reg and kind.
  - If `scan_re` = 0, issue the RAM read and go to CAP; otherwise go to RD.
- RD: issue the RAM read in the first cycle with `scan_re` = 0, then go to CAP.
- CAP: capture the RAM output into the word register; go to WB.
- WB, write command: write the modified word in a cycle with `scan_re` = 0 (hold in WB otherwise), then go to IDLE. An illegal action leaves WB immediately and pulses `cmd_err`.
- WB, read command: pulse `rd_valid` with `rd_data` and `rd_dst_reg` for one cycle, then go to IDLE.

`stall` = (state != IDLE). It is combinational from the state register.

## Timing
Uncontended command accepted in cycle T:
- T+1: CAP.
- T+2: WB. A write lands at the end of T+2; for a read, `rd_valid` is high in T+2.
- T+3: IDLE; the next command can be accepted.
- `stall` is high in T+1 and T+2.
- Each cycle of `scan_re` contention adds one cycle in RD or WB.

Scan port:
- `scan_re` in cycle S gives valid `scan_data` in S+1.
- `scan_data` is 0 in any cycle not following a granted scan read.

Read-after-write:
- A read accepted after the write's WB cycle sees the new value.
- A scan read in the same cycle as a pending write sees the old value.

Reset values: `stall` 0 (1 if clear is enabled), `rd_valid` 0, `rd_data` 0, `rd_dst_reg` 0, `cmd_err` 0, `scan_data` 0.

Reset mid-command: the FSM returns to IDLE (or CLR) and the latched command is discarded. RAM contents are not restored.

## Configuration
Macro: `SPRITE_INIT_CLEAR_EN`.

Defined:
- After reset the FSM enters CLR.
- An 8-bit counter writes 0 to entries 0..255, one per cycle with `scan_re` = 0; scan reads stall the counter.
- `stall` stays high throughout CLR; the FSM enters IDLE after entry 255.
- If there is no scan contention, the clear takes 256 cycles.

Undefined:
- Reset goes directly to IDLE and RAM contents are unspecified.

## Test plan
1. SET_X, sprite 5, imm 0x123, then RD sprite 5 with `dst_reg` 7: `rd_valid` at T+2, `rd_data[11:0]` = 0x123, `rd_dst_reg` = 7; `stall` is high for exactly 2 cycles per command.
2. SET_XY with register 0x00ABC123, then CORD: `rd_data` = 0x0ABC0123.
3. SET_X 0xFFE, then MOVE_X with imm 0x0004: x = 0x002 (wrap). Then MOVE_X with imm 0x3FFD (−3): x = 0xFFF.
4. `scan_re` held high for 3 cycles during a write command: the write completes 3 cycles late, and `scan_data` returns the pre-write word.
5. Action 0xA on sprite 9: `cmd_err` pulses once and the entry is unchanged on a later RD. Separately, `sprite_we` and `sprite_re` both high: the write is performed and `rd_valid` stays 0.
6. Assert `rst_n` low during a write's CAP state: all outputs are 0 and the entry is unchanged. With `SPRITE_INIT_CLEAR_EN` defined, `stall` is high for 256 cycles and RD of sprite 255 returns 0.
